frame_write_sched: RTL and testbench

Write-side controller placed between the camera capture stage and the frame-buffer memory arbiter, in the `pclk` domain. Arms on a software start and aligns to the next frame (falling edge of `vsync`). Packs accepted 24-bit pixels into a small internal FIFO and issues fixed-length write bursts through a request/grant handshake. On frame end it flushes any residual pixels as one short burst, then reports completion.

---
 rtl/frame_write_sched.sv | 157 +++++++++++++++
 tb/tb_frame_write_sched.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_write_sched.sv
// rtl/frame_write_sched.sv - frame-aligned pixel packer and burst write scheduler
// Define FRAME_WRITE_SCHED_DBUF_EN for double buffering (buf_sel ping-pongs per frame).
module frame_write_sched #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_AW    = 6,
  parameter int ADDR_W     = 19,
  parameter int FRAME_BASE = 0,
  localparam int LEN_W     = $clog2(BURST_LEN) + 1
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              continuous,
  input  logic              vsync,
  input  logic              pix_valid,
  input  logic [23:0]       pix_data,
  output logic              wr_req,
  input  logic              wr_gnt,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [LEN_W-1:0]  wr_len,
  output logic              wr_valid,
  output logic [23:0]       wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow,
  output logic [7:0]        frame_cnt,
  output logic              buf_sel
);

  localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;
  localparam int PC_W      = $clog2(FRAME_PIX + 1);
  localparam int DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]    FULL_CNT  = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]    BURST_CNT = (FIFO_AW+1)'(BURST_LEN);
  localparam logic [PC_W-1:0]     PIX_MAX   = PC_W'(FRAME_PIX);
  localparam logic [PC_W-1:0]     PIX_LAST  = PC_W'(FRAME_PIX - 1);
  localparam logic [ADDR_W-1:0]   BASE0     = ADDR_W'(FRAME_BASE);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, FLUSH} state_t;

  state_t             state;
  logic               vs_q;
  logic [PC_W-1:0]    pix_cnt;
  logic [23:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wp, rp;
  logic [FIFO_AW:0]   count;
  logic [ADDR_W-1:0]  wr_ptr;
  logic [LEN_W-1:0]   beats_rem;
  logic [ADDR_W-1:0]  frame_base;
  logic [LEN_W-1:0]   avail_len;
  logic vs_fall, vs_rise, take, full, push, pop, gnt_ok, raise, drained;

`ifdef FRAME_WRITE_SCHED_DBUF_EN
  localparam logic [ADDR_W-1:0] BASE1 = ADDR_W'(FRAME_BASE + FRAME_PIX);
  assign frame_base = buf_sel ? BASE1 : BASE0;
`else
  assign frame_base = BASE0;
`endif

  assign busy    = (state != IDLE);
  assign vs_fall = vs_q & ~vsync;
  assign vs_rise = ~vs_q & vsync;
  assign take    = (state == CAPTURE) && pix_valid && (pix_cnt < PIX_MAX);
  assign full    = (count == FULL_CNT);
  assign push    = take && !full;
  assign gnt_ok  = wr_req && wr_gnt;
  // Beats are launched (and the FIFO popped) on the grant edge and each following edge.
  assign pop     = gnt_ok || (wr_valid && beats_rem != '0);
  assign avail_len = (count < BURST_CNT) ? LEN_W'(count) : LEN_W'(BURST_LEN);
  assign raise   = !wr_req && !wr_valid &&
                   ((count >= BURST_CNT) || ((state == FLUSH) && count != '0));
  // Drained now, or the final beat is on the bus this cycle with nothing left behind it.
  assign drained = (count == '0) && !wr_req && (!wr_valid || beats_rem == '0);

  always_ff @(posedge pclk) begin
    if (push) mem[wp] <= pix_data;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vs_q       <= 1'b0;
      pix_cnt    <= '0;
      wp         <= '0;
      rp         <= '0;
      count      <= '0;
      wr_ptr     <= '0;
      beats_rem  <= '0;
      wr_req     <= 1'b0;
      wr_addr    <= '0;
      wr_len     <= '0;
      wr_valid   <= 1'b0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      frame_cnt  <= '0;
      buf_sel    <= 1'b0;
    end else begin
      vs_q       <= vsync;
      frame_done <= 1'b0;

      if (push) wp <= wp + FIFO_AW'(1);
      if (pop)  rp <= rp + FIFO_AW'(1);
      if (push && !pop)      count <= count + (FIFO_AW+1)'(1);
      else if (!push && pop) count <= count - (FIFO_AW+1)'(1);

      if (take) pix_cnt <= pix_cnt + PC_W'(1);
      if (take && full) overflow <= 1'b1;

      if (raise) begin
        wr_req  <= 1'b1;
        wr_len  <= avail_len;
        wr_addr <= frame_base + wr_ptr;
      end else if (gnt_ok) begin
        wr_req    <= 1'b0;
        wr_valid  <= 1'b1;
        wr_data   <= mem[rp];
        beats_rem <= wr_len - LEN_W'(1);
      end else if (wr_valid) begin
        if (beats_rem != '0) begin
          wr_data   <= mem[rp];
          beats_rem <= beats_rem - LEN_W'(1);
        end else begin
          wr_valid <= 1'b0;
          wr_ptr   <= wr_ptr + ADDR_W'(wr_len);
        end
      end

      case (state)
        IDLE: if (start) begin
          state    <= WAIT_VS;
          overflow <= 1'b0;
          pix_cnt  <= '0;
          wr_ptr   <= '0;
        end
        WAIT_VS: if (vs_fall) begin
          state   <= CAPTURE;
          pix_cnt <= '0;
        end
        CAPTURE: if (vs_rise || (take && pix_cnt == PIX_LAST)) state <= FLUSH;
        FLUSH: if (drained) begin
          frame_done <= 1'b1;
          frame_cnt  <= frame_cnt + 8'd1;
          wr_ptr     <= '0;
`ifdef FRAME_WRITE_SCHED_DBUF_EN
          buf_sel    <= ~buf_sel;
`endif
          state      <= continuous ? WAIT_VS : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_write_sched.sv
// tb/tb_frame_write_sched.sv - directed vector bench for frame_write_sched
module tb_frame_write_sched;
  localparam int FPIX = 16;
`ifdef FRAME_WRITE_SCHED_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic pclk, rst_n, start, continuous, vsync, pix_valid, wr_gnt;
  logic [23:0] pix_data;
  logic wr_req, wr_valid, busy, frame_done, overflow, buf_sel;
  logic [18:0] wr_addr;
  logic [2:0]  wr_len;
  logic [23:0] wr_data;
  logic [7:0]  frame_cnt;

  frame_write_sched #(.H_ACTIVE(8), .V_ACTIVE(2), .BURST_LEN(4), .FIFO_AW(3),
                      .ADDR_W(19), .FRAME_BASE(0)) dut (
    .pclk(pclk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .vsync(vsync), .pix_valid(pix_valid), .pix_data(pix_data),
    .wr_req(wr_req), .wr_gnt(wr_gnt), .wr_addr(wr_addr), .wr_len(wr_len),
    .wr_valid(wr_valid), .wr_data(wr_data), .busy(busy), .frame_done(frame_done),
    .overflow(overflow), .frame_cnt(frame_cnt), .buf_sel(buf_sel));

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    int n_pix; int gap; bit vs_end; bit gnt_hold;
    int exp_bursts; int exp_last_len; bit exp_ovf; int exp_words;
  } vec_t;

  int n_err = 0, n_chk = 0;
  int exp_fcnt = 0;
  bit exp_buf = 1'b0;
  bit gnt_en = 1'b1;
  int req_age = 0;
  int cyc = 0, last_beat_cyc = 0, done_cyc = 0, done_cnt = 0;
  logic req_q = 1'b0, done_busy = 1'b0, done_buf = 1'b0;
  int q_addr[$], q_len[$], q_data[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Arbiter: grant on the second cycle a request is seen, one-cycle pulse.
  initial begin
    wr_gnt = 1'b0;
    forever begin
      @(negedge pclk);
      if (wr_gnt) wr_gnt = 1'b0;
      else if (wr_req && gnt_en) begin
        if (req_age >= 1) begin wr_gnt = 1'b1; req_age = 0; end
        else req_age++;
      end else req_age = 0;
    end
  end

  initial begin
    forever begin
      @(negedge pclk);
      cyc++;
      if (wr_req && !req_q) begin q_addr.push_back(int'(wr_addr)); q_len.push_back(int'(wr_len)); end
      req_q = wr_req;
      if (wr_valid) begin q_data.push_back(int'(wr_data)); last_beat_cyc = cyc; end
      if (frame_done) begin done_cnt++; done_cyc = cyc; done_busy = busy; done_buf = buf_sel; end
    end
  end

  task automatic vs_pulse();
    vsync = 1'b1;
    @(posedge pclk); #1;
    vsync = 1'b0;
    @(posedge pclk); #1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    @(posedge pclk); #1;
    start = 1'b0;
    vs_pulse();
  endtask

  task automatic drive_pix(input int n, input int gap, input int id);
    for (int i = 1; i <= n; i++) begin
      pix_valid = 1'b1;
      pix_data  = 24'(i + (id << 16));
      @(posedge pclk); #1;
      pix_valid = 1'b0;
      repeat (gap) begin @(posedge pclk); #1; end
    end
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (done_cnt < target && t < 400) begin @(posedge pclk); t++; end
    chk("done_seen", (done_cnt >= target), 1);
  endtask

  task automatic clear_q();
    q_addr.delete(); q_len.delete(); q_data.delete();
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int base, nb, nw;
    clear_q();
    done_cnt = 0;
    gnt_en = !v.gnt_hold;
    start_frame();
    chk("ovf_clear", overflow, 0);
    chk("busy_armed", busy, 1);
    drive_pix(v.n_pix, v.gap, id);
    if (v.vs_end) vsync = 1'b1;
    gnt_en = 1'b1;
    wait_done(1);
    base = (DBUF && exp_buf) ? FPIX : 0;
    exp_fcnt++;
    if (DBUF) exp_buf = ~exp_buf;
    chk("burst_count", q_addr.size(), v.exp_bursts);
    nb = (q_addr.size() < v.exp_bursts) ? q_addr.size() : v.exp_bursts;
    for (int i = 0; i < nb; i++) begin
      chk("burst_addr", q_addr[i], base + 4 * i);
      chk("burst_len", q_len[i], (i == v.exp_bursts - 1) ? v.exp_last_len : 4);
    end
    chk("word_count", q_data.size(), v.exp_words);
    nw = (q_data.size() < v.exp_words) ? q_data.size() : v.exp_words;
    for (int i = 0; i < nw; i++) chk("beat_data", q_data[i], (i + 1) + (id << 16));
    if (v.exp_words > 0) chk("done_lag", done_cyc - last_beat_cyc, 1);
    chk("frame_cnt", frame_cnt, exp_fcnt & 255);
    chk("idle_after", done_busy, 0);
    chk("buf_sel", done_buf, exp_buf);
    chk("overflow", overflow, v.exp_ovf);
    repeat (6) @(posedge pclk);
    #1;
    chk("single_done", done_cnt, 1);
  endtask

  vec_t vecs[6];
  int base2, t;

  initial begin
    rst_n = 1'b0; start = 1'b0; continuous = 1'b0; vsync = 1'b0;
    pix_valid = 1'b0; pix_data = '0;
    vecs[0] = '{16, 1, 1'b0, 1'b0, 4, 4, 1'b0, 16};
    vecs[1] = '{6,  1, 1'b1, 1'b0, 2, 2, 1'b0, 6};
    vecs[2] = '{10, 0, 1'b1, 1'b1, 2, 4, 1'b1, 8};
    vecs[3] = '{20, 1, 1'b0, 1'b0, 4, 4, 1'b0, 16};
    vecs[4] = '{3,  1, 1'b1, 1'b0, 1, 3, 1'b0, 3};
    vecs[5] = '{0,  1, 1'b1, 1'b0, 0, 0, 1'b0, 0};
    repeat (3) @(posedge pclk);
    #1;
    chk("reset_outs", {wr_req, wr_valid, wr_addr, wr_len, wr_data, busy, frame_done,
                       overflow, frame_cnt, buf_sel}, 0);
    rst_n = 1'b1;
    @(posedge pclk); #1;

    for (int k = 0; k < 6; k++) run_vec(vecs[k], k + 1);

    // Two back-to-back frames with auto re-arm, continuous dropped during the second.
    clear_q();
    done_cnt = 0;
    continuous = 1'b1;
    start_frame();
    drive_pix(16, 1, 8);
    wait_done(1);
    exp_fcnt++;
    if (DBUF) exp_buf = ~exp_buf;
    chk("cont_rearm_busy", done_busy, 1);
    chk("cont_buf1", done_buf, exp_buf);
    chk("cont_cnt1", frame_cnt, exp_fcnt & 255);
    base2 = (DBUF && exp_buf) ? FPIX : 0;
    clear_q();
    vs_pulse();
    continuous = 1'b0;
    drive_pix(16, 1, 9);
    wait_done(2);
    exp_fcnt++;
    if (DBUF) exp_buf = ~exp_buf;
    chk("cont_f2_bursts", q_addr.size(), 4);
    if (q_addr.size() > 0) chk("cont_f2_addr", q_addr[0], base2);
    chk("cont_f2_data0", (q_data.size() > 0) ? q_data[0] : -1, 1 + (9 << 16));
    chk("cont_end_idle", done_busy, 0);
    chk("cont_buf2", done_buf, exp_buf);
    chk("cont_cnt2", frame_cnt, exp_fcnt & 255);

    // Reset during the third beat of a burst.
    clear_q();
    gnt_en = 1'b1;
    start_frame();
    drive_pix(4, 0, 10);
    t = 0;
    while (q_data.size() < 2 && t < 100) begin @(posedge pclk); t++; end
    chk("beat2_seen", (q_data.size() >= 2), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outs", {wr_req, wr_valid, wr_addr, wr_len, wr_data, busy, frame_done,
                             overflow, frame_cnt, buf_sel}, 0);
    @(posedge pclk);
    #1;
    t = q_data.size();
    repeat (3) @(posedge pclk);
    #1;
    chk("no_beats_in_reset", q_data.size(), t);
    rst_n = 1'b1;
    exp_fcnt = 0;
    exp_buf = 1'b0;
    @(posedge pclk); #1;
    run_vec('{4, 1, 1'b1, 1'b0, 1, 4, 1'b0, 4}, 11);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
